// File: rtl/control_sequencer.sv
// Step-sequencing control unit: fetch / decode / execute with memory ready handshake.
// Build option ILLEGAL_TRAP_EN: unlisted opcodes trap into HALT and raise illegal.
module control_sequencer #(
  parameter int ALU_OP_W = 5,
  parameter int OP_W     = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         IR,
  input  logic                CON_FF,
  input  logic                mem_ready,
  input  logic                stop,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Cout,
  output logic                CONin,
  output logic                Read,
  output logic                Write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                run,
  output logic                instr_done,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'b00001);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00010);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(5'b10100);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11001);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11010);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(5'b00011);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] ir_op;
  logic [OP_W-1:0] op;
  logic            unused_ir;

  logic is_rr, is_addi, is_ldi, is_ld, is_st, is_br, is_jr, is_nop, is_halt, is_legal;

  assign ir_op     = IR[31 -: OP_W];
  assign unused_ir = ^IR[31-OP_W:0];

  // IR is loaded at the end of T2, so T3 dispatches on it directly; later steps use the copy.
  assign op = (state_q == S_T3) ? ir_op : op_q;

  assign is_rr    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_addi  = (op == OP_ADDI);
  assign is_ldi   = (op == OP_LDI);
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_br    = (op == OP_BR);
  assign is_jr    = (op == OP_JR);
  assign is_nop   = (op == OP_NOP);
  assign is_halt  = (op == OP_HALT);
  assign is_legal = is_rr || is_addi || is_ldi || is_ld || is_st || is_br ||
                    is_jr || is_nop || is_halt;

  assign run = (state_q != S_IDLE) && (state_q != S_HALT);

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_T3) op_q <= ir_op;
`ifdef ILLEGAL_TRAP_EN
      if (state_q == S_T3 && !is_legal) illegal_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Cout       = 1'b0;
    CONin      = 1'b0;
    Read       = 1'b0;
    Write      = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0: begin
        // A halt request suppresses the fetch strobes so the PC is left untouched.
        if (stop) begin
          state_d = S_HALT;
        end else begin
          PCout   = 1'b1;
          MARin   = 1'b1;
          IncPC   = 1'b1;
          Zin     = 1'b1;
          state_d = S_T1;
        end
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = mem_ready;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_rr || is_addi) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = S_T4;
        end else if (is_ldi || is_ld || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = S_T4;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_d = S_T4;
        end else if (is_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; instr_done = 1'b1; state_d = S_T0;
        end else if (is_nop) begin
          instr_done = 1'b1; state_d = S_T0;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          instr_done = 1'b1;
          state_d    = S_T0;
`endif
        end
      end
      S_T4: begin
        if (is_rr) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_OP_W'(op); state_d = S_T5;
        end else if (is_addi || is_ldi || is_ld || is_st) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; state_d = S_T5;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1; state_d = S_T5;
        end else begin
          state_d = S_T0;
        end
      end
      S_T5: begin
        if (is_rr || is_addi || is_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; state_d = S_T0;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1; state_d = S_T6;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; state_d = S_T6;
        end else begin
          state_d = S_T0;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read  = 1'b1;
          MDRin = mem_ready;
          if (mem_ready) state_d = S_T7;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = S_T7;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = CON_FF; instr_done = 1'b1; state_d = S_T0;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; state_d = S_T0;
        end else if (is_st) begin
          Write      = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) state_d = S_T0;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a per-instruction step table model predicts every cycle's outputs.
module tb_control_sequencer;

  typedef logic [27:0] vec_t;

  localparam vec_t M_GRA    = 28'd1 << 27;
  localparam vec_t M_GRB    = 28'd1 << 26;
  localparam vec_t M_GRC    = 28'd1 << 25;
  localparam vec_t M_RIN    = 28'd1 << 24;
  localparam vec_t M_ROUT   = 28'd1 << 23;
  localparam vec_t M_BAOUT  = 28'd1 << 22;
  localparam vec_t M_PCOUT  = 28'd1 << 21;
  localparam vec_t M_PCIN   = 28'd1 << 20;
  localparam vec_t M_INCPC  = 28'd1 << 19;
  localparam vec_t M_MARIN  = 28'd1 << 18;
  localparam vec_t M_MDRIN  = 28'd1 << 17;
  localparam vec_t M_MDROUT = 28'd1 << 16;
  localparam vec_t M_IRIN   = 28'd1 << 15;
  localparam vec_t M_YIN    = 28'd1 << 14;
  localparam vec_t M_ZIN    = 28'd1 << 13;
  localparam vec_t M_ZLOW   = 28'd1 << 12;
  localparam vec_t M_COUT   = 28'd1 << 11;
  localparam vec_t M_CONIN  = 28'd1 << 10;
  localparam vec_t M_READ   = 28'd1 << 9;
  localparam vec_t M_WRITE  = 28'd1 << 8;
  localparam vec_t M_RUN    = 28'd1 << 7;
  localparam vec_t M_DONE   = 28'd1 << 6;
  localparam vec_t M_ILL    = 28'd1 << 5;
  localparam vec_t M_ADD    = 28'd3;

  logic        clock, clear, CON_FF, mem_ready, stop;
  logic [31:0] IR;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic        IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write, run, instr_done, illegal;
  logic [4:0]  alu_op;
  vec_t        obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mr;
    logic        con;
    logic        stp;
    logic [31:0] ir;
    vec_t        v;
  } step_t;

  step_t exp_q[$];

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .mem_ready(mem_ready), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin),
    .Read(Read), .Write(Write), .alu_op(alu_op), .run(run), .instr_done(instr_done),
    .illegal(illegal)
  );

  assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write, run, instr_done, illegal,
                alu_op};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add_step(input logic mr, input logic con, input logic stp,
                                   input logic [31:0] ir, input vec_t v);
    step_t s;
    s.mr = mr; s.con = con; s.stp = stp; s.ir = ir; s.v = v;
    exp_q.push_back(s);
  endfunction

  // Expected cycle list for one instruction from fetch to its last step.
  function automatic void build(input logic [31:0] ir, input int w1, input int wm, input logic con);
    logic [4:0] op;
    op = ir[31:27];
    add_step(rb(), rb(), 1'b0, ir, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    for (int i = 0; i < w1; i++) add_step(1'b0, rb(), rb(), ir, M_RUN | M_ZLOW | M_PCIN | M_READ);
    add_step(1'b1, rb(), rb(), ir, M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN);
    add_step(rb(), rb(), rb(), ir, M_RUN | M_MDROUT | M_IRIN);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        add_step(rb(), rb(), rb(), ir, M_RUN | M_GRB | M_ROUT | M_YIN);
        add_step(rb(), rb(), rb(), ir, M_RUN | M_GRC | M_ROUT | M_ZIN | vec_t'(op));
        add_step(rb(), rb(), rb(), ir, M_RUN | M_ZLOW | M_GRA | M_RIN | M_DONE);
      end
      5'd12, 5'd1: begin
        add_step(rb(), rb(), rb(), ir,
                 M_RUN | M_GRB | M_YIN | ((op == 5'd12) ? M_ROUT : M_BAOUT));
        add_step(rb(), rb(), rb(), ir, M_RUN | M_COUT | M_ZIN | M_ADD);
        add_step(rb(), rb(), rb(), ir, M_RUN | M_ZLOW | M_GRA | M_RIN | M_DONE);
      end
      5'd0, 5'd2: begin
        add_step(rb(), rb(), rb(), ir, M_RUN | M_GRB | M_BAOUT | M_YIN);
        add_step(rb(), rb(), rb(), ir, M_RUN | M_COUT | M_ZIN | M_ADD);
        add_step(rb(), rb(), rb(), ir, M_RUN | M_ZLOW | M_MARIN);
        if (op == 5'd0) begin
          for (int i = 0; i < wm; i++) add_step(1'b0, rb(), rb(), ir, M_RUN | M_READ);
          add_step(1'b1, rb(), rb(), ir, M_RUN | M_READ | M_MDRIN);
          add_step(rb(), rb(), rb(), ir, M_RUN | M_MDROUT | M_GRA | M_RIN | M_DONE);
        end else begin
          add_step(rb(), rb(), rb(), ir, M_RUN | M_GRA | M_ROUT | M_MDRIN);
          for (int i = 0; i < wm; i++) add_step(1'b0, rb(), rb(), ir, M_RUN | M_WRITE);
          add_step(1'b1, rb(), rb(), ir, M_RUN | M_WRITE | M_DONE);
        end
      end
      5'd18: begin
        add_step(rb(), rb(), rb(), ir, M_RUN | M_GRA | M_ROUT | M_CONIN);
        add_step(rb(), rb(), rb(), ir, M_RUN | M_PCOUT | M_YIN);
        add_step(rb(), rb(), rb(), ir, M_RUN | M_COUT | M_ZIN | M_ADD);
        add_step(rb(), con, rb(), ir, M_RUN | M_ZLOW | M_DONE | (con ? M_PCIN : vec_t'(0)));
      end
      5'd20: add_step(rb(), rb(), rb(), ir, M_RUN | M_GRA | M_ROUT | M_PCIN | M_DONE);
      5'd25: add_step(rb(), rb(), rb(), ir, M_RUN | M_DONE);
      5'd26: add_step(rb(), rb(), rb(), ir, M_RUN);
      default: begin
`ifdef ILLEGAL_TRAP_EN
        add_step(rb(), rb(), rb(), ir, M_RUN);
`else
        add_step(rb(), rb(), rb(), ir, M_RUN | M_DONE);
`endif
      end
    endcase
  endfunction

  task automatic run_queue(input string name, input int max);
    step_t s;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      s = exp_q.pop_front();
      @(negedge clock);
      mem_ready = s.mr; CON_FF = s.con; stop = s.stp; IR = s.ir;
      #1;
      checks++;
      if (obs !== s.v) begin
        errors++;
        $display("FAIL %s step %0d: observed %h expected %h", name, n, obs, s.v);
      end
      n++;
    end
  endtask

  task automatic idle_check(input string name, input int cycles, input vec_t v);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      mem_ready = rb(); CON_FF = rb(); stop = rb(); IR = $urandom;
      #1;
      checks++;
      if (obs !== v) begin
        errors++;
        $display("FAIL %s cycle %0d: observed %h expected %h", name, i, obs, v);
      end
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clock);
    #2 clear = 1'b0;
    #1;
    checks++;
    if (obs !== 28'd0) begin
      errors++;
      $display("FAIL %s_async: observed %h expected %h", name, obs, 28'd0);
    end
    idle_check({name, "_held"}, 2, 28'd0);
    @(negedge clock);
    clear = 1'b1; stop = 1'b0;
    #1;
    checks++;
    if (obs !== 28'd0) begin
      errors++;
      $display("FAIL %s_idle: observed %h expected %h", name, obs, 28'd0);
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_add();
    build(32'h18918000, 0, 0, 1'b0);
    build({5'd25, 27'($urandom)}, 1, 0, 1'b0);
    run_queue("add", 1000);
  endtask

  task automatic test_ld_wait();
    build(32'h02000020, 2, 3, 1'b0);
    build(32'h10000000, 0, 2, 1'b0);
    run_queue("ld_st_wait", 1000);
  endtask

  task automatic test_branch();
    build(32'h90000000, 0, 0, 1'b0);
    build(32'h90000000, 1, 0, 1'b1);
    run_queue("branch", 1000);
  endtask

  task automatic test_random();
    logic [4:0] ops [11];
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd20, 5'd25};
    for (int k = 0; k < 30; k++) begin
      build({ops[$urandom_range(0, 10)], 27'($urandom)}, $urandom_range(0, 3),
            $urandom_range(0, 3), rb());
      run_queue("random", 1000);
    end
  endtask

  task automatic test_reset_mid();
    build(32'h02000020, 0, 6, 1'b0);
    run_queue("mid_pre", 8);
    exp_q.delete();
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== (M_RUN | M_READ)) begin
      errors++;
      $display("FAIL mid_wait: observed %h expected %h", obs, M_RUN | M_READ);
    end
    do_reset("mid_reset");
  endtask

  task automatic test_halt();
    build(32'hD0000000, 1, 0, 1'b0);
    run_queue("halt", 1000);
    idle_check("halt_hold", 20, 28'd0);
    do_reset("halt_reset");
  endtask

  task automatic test_stop();
    add_step(rb(), rb(), 1'b1, 32'h18918000, M_RUN);
    run_queue("stop_t0", 1000);
    idle_check("stop_hold", 5, 28'd0);
    do_reset("stop_reset");
  endtask

  task automatic test_illegal();
    build(32'hF8000000, 0, 0, 1'b0);
    run_queue("illegal", 1000);
`ifdef ILLEGAL_TRAP_EN
    idle_check("illegal_hold", 10, M_ILL);
    do_reset("illegal_reset");
`else
    build(32'h18918000, 0, 0, 1'b0);
    run_queue("illegal_next", 1000);
`endif
  endtask

  initial begin
    clear = 1'b0; stop = 1'b0; mem_ready = 1'b0; CON_FF = 1'b0; IR = '0;
    test_reset();
    test_add();
    test_ld_wait();
    test_branch();
    test_random();
    test_reset_mid();
    test_halt();
    test_stop();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
